// File: rtl/lfsr_word_gen_pkg.sv
// lfsr_word_gen shared package: FSM states, default taps/seeds, Galois step.
// Used by lfsr_galois_step and lfsr_word_gen.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lfsr_state_e;

    // Right-shift Galois masks (maximal length) and default seeds
    localparam logic [15:0] POLY16 = 16'hB400;
    localparam logic [15:0] SEED16 = 16'h0001;
    localparam logic [31:0] POLY32 = 32'h80200003;
    localparam logic [31:0] SEED32 = 32'h00000001;
    localparam logic [63:0] POLY64 = 64'hD800000000000000;
    localparam logic [63:0] SEED64 = 64'h0000000000000001;

    function automatic logic [63:0] galois_step(
        input logic [63:0] v,
        input logic [63:0] poly
    );
        return (v >> 1) ^ (v[0] ? poly : 64'd0);
    endfunction

endpackage

// File: rtl/lfsr_word_gen_if.sv
// Valid/ready word stream carried from lfsr_word_gen to its consumer.
// master drives valid/data, slave drives ready.
interface lfsr_word_gen_if #(
    parameter int WIDTH = 32
);
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/lfsr_word_gen_step.sv
// Combinational one-step advance of a right-shift Galois LFSR.
// Parameterised by WIDTH and feedback mask POLY.
module lfsr_galois_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY32)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);
    always_comb begin
        nxt = WIDTH'(galois_step(64'(cur), 64'(POLY)));
    end
endmodule

// File: rtl/lfsr_word_gen.sv
// Burst generator of Galois LFSR words on a valid/ready stream.
// Optional stall counter built when LFSR_STALL_CNT_EN is defined.
module lfsr_word_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY32),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED32),
    parameter int               CNT_W = 16
) (
    input  logic                 up_clk,
    input  logic                 up_rst,
    input  logic [WIDTH-1:0]     cfg_seed,
    input  logic                 cfg_seed_load,
    input  logic [CNT_W-1:0]     cfg_burst_len,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    lfsr_word_gen_if.master      m_if,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [31:0]          stall_cnt
);
    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] lfsr_next;
    logic             hs;
    logic             last;
    logic             start_ok;

    lfsr_galois_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .cur (lfsr_q),
        .nxt (lfsr_next)
    );

    assign hs       = valid_q && m_if.m_ready;
    assign last     = (cnt_q + CNT_W'(1)) == len_q;
    assign start_ok = (state_q == ST_IDLE) && !cfg_seed_load
                   && cfg_start && (cfg_burst_len != '0);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_seed_load) begin
                    lfsr_d = (cfg_seed == '0) ? SEED : cfg_seed;
                end else if (start_ok) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    len_d   = cfg_burst_len;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    data_d  = lfsr_q;
                    valid_d = 1'b1;
                    lfsr_d  = lfsr_next;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // final handshake beats a coincident abort
                if (hs && last) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cfg_abort) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (hs) begin
                    data_d = lfsr_q;
                    lfsr_d = lfsr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef LFSR_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (valid_q && !m_if.m_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign m_if.m_valid = valid_q;
    assign m_if.m_data  = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_cnt     = cnt_q;
endmodule

// File: tb/tb_lfsr_word_gen.sv
// Self-checking bench for lfsr_word_gen: burst-level model plus literal pins.
// Honours LFSR_STALL_CNT_EN for the expected stall count.
module tb_lfsr_word_gen;
    localparam logic [31:0] P = 32'h80200003;

    logic        up_clk = 1'b0;
    logic        up_rst = 1'b1;
    logic [31:0] cfg_seed = '0;
    logic        cfg_seed_load = 1'b0;
    logic [15:0] cfg_burst_len = '0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        busy, done;
    logic [15:0] word_cnt;
    logic [31:0] stall_cnt;

    lfsr_word_gen_if #(.WIDTH(32)) bus ();

    lfsr_word_gen dut (
        .up_clk        (up_clk),
        .up_rst        (up_rst),
        .cfg_seed      (cfg_seed),
        .cfg_seed_load (cfg_seed_load),
        .cfg_burst_len (cfg_burst_len),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .m_if          (bus),
        .busy          (busy),
        .done          (done),
        .word_cnt      (word_cnt),
        .stall_cnt     (stall_cnt)
    );

    always #5 up_clk = ~up_clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;
    logic [31:0] acc[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] x);
        logic [31:0] h;
        h = x / 2;
        return (x % 2 == 1) ? (h ^ P) : h;
    endfunction

    // burst-level model: "cursor" is the next word the generator will present
    bit          e_valid = 0, e_busy = 0, e_done = 0, e_first = 0;
    logic [31:0] e_data = '0, cursor = 32'h1;
    int          e_cnt = 0, e_len = 0;
    logic [31:0] e_stall = '0;

    always @(negedge up_clk) begin
        logic [31:0] xs;
        check("m_valid", 64'(bus.m_valid), 64'(e_valid));
        if (e_valid) check("m_data", 64'(bus.m_data), 64'(e_data));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("word_cnt", 64'(word_cnt), 64'(e_cnt));
`ifdef LFSR_STALL_CNT_EN
        xs = e_stall;
`else
        xs = '0;
`endif
        check("stall_cnt", 64'(stall_cnt), 64'(xs));
        if (done) done_seen++;
        if (bus.m_valid && bus.m_ready) acc.push_back(bus.m_data);
        if (up_rst) begin
            e_valid = 0; e_busy = 0; e_done = 0; e_first = 0;
            e_data = '0; cursor = 32'h1; e_cnt = 0; e_stall = '0;
        end else begin
            e_done = 0;
            if (e_valid && !bus.m_ready && e_stall != 32'hFFFFFFFF)
                e_stall = e_stall + 1;
            if (!e_busy) begin
                if (cfg_seed_load)
                    cursor = (cfg_seed == 0) ? 32'h1 : cfg_seed;
                else if (cfg_start && cfg_burst_len != 0) begin
                    e_busy = 1; e_first = 1; e_cnt = 0;
                    e_len = int'(cfg_burst_len); e_stall = '0;
                end
            end else if (e_first) begin
                e_first = 0;
                if (cfg_abort) e_busy = 0;
                else begin
                    e_valid = 1; e_data = cursor; cursor = adv(cursor);
                end
            end else begin
                if (bus.m_ready) e_cnt++;
                if (bus.m_ready && e_cnt == e_len) begin
                    e_valid = 0; e_busy = 0; e_done = 1;
                end else if (cfg_abort) begin
                    e_valid = 0; e_busy = 0;
                end else if (bus.m_ready) begin
                    e_data = cursor; cursor = adv(cursor);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge up_clk);
            #1;
        end
    endtask

    task automatic start(input int len);
        cfg_burst_len = 16'(len);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic seed_load(input logic [31:0] s);
        cfg_seed = s;
        cfg_seed_load = 1'b1;
        tick();
        cfg_seed_load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        check({name, "_done_timeout"}, 64'(done), 64'd1);
        tick();
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!bus.m_valid && k < 20) begin
            tick();
            k++;
        end
        check({name, "_valid_timeout"}, 64'(bus.m_valid), 64'd1);
    endtask

    task automatic wait_cnt(input int n);
        int k;
        k = 0;
        while (int'(word_cnt) != n && k < 40) begin
            tick();
            k++;
        end
        check("wait_cnt_timeout", 64'(word_cnt), 64'(n));
    endtask

    int d0;

    initial begin
        bus.m_ready = 1'b1;
        tick(3);
        up_rst = 1'b0;
        check("rst_m_data", 64'(bus.m_data), 64'h0);
        check("rst_valid", 64'(bus.m_valid), 64'h0);
        tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'h0);

        acc.delete();
        start(3);
        wait_done("len3");
        check("len3_n", 64'(acc.size()), 64'd3);
        if (acc.size() == 3) begin
            check("len3_w0", 64'(acc[0]), 64'h00000001);
            check("len3_w1", 64'(acc[1]), 64'h80200003);
            check("len3_w2", 64'(acc[2]), 64'hC0300002);
        end
        check("len3_dones", 64'(done_seen), 64'd1);
        check("len3_cnt", 64'(word_cnt), 64'd3);
        check("len3_busy", 64'(busy), 64'd0);

        seed_load(32'h0);
        acc.delete();
        start(1);
        wait_done("zero_seed");
        if (acc.size() > 0) check("zero_seed_w", 64'(acc[0]), 64'h1);
        else check("zero_seed_n", 64'(acc.size()), 64'd1);

        seed_load(32'h1);
        acc.delete();
        bus.m_ready = 1'b0;
        start(4);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 64'(bus.m_data), 64'h1);
            tick();
        end
        bus.m_ready = 1'b1;
        wait_done("stall");
`ifdef LFSR_STALL_CNT_EN
        check("stall_total", 64'(stall_cnt), 64'd5);
`else
        check("stall_total", 64'(stall_cnt), 64'd0);
`endif
        check("stall_n", 64'(acc.size()), 64'd4);
        if (acc.size() == 4) check("stall_w3", 64'(acc[3]), 64'h60180001);

        seed_load(32'h1);
        d0 = done_seen;
        start(10);
        wait_cnt(2);
        bus.m_ready = 1'b0;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_valid", 64'(bus.m_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cnt", 64'(word_cnt), 64'd2);
        tick(2);
        check("abort_nodone", 64'(done_seen), 64'(d0));
        bus.m_ready = 1'b1;
        acc.delete();
        start(1);
        wait_done("after_abort");
        if (acc.size() > 0) check("after_abort_w", 64'(acc[0]), 64'h60180001);
        else check("after_abort_n", 64'(acc.size()), 64'd1);

        d0 = done_seen;
        start(0);
        tick(3);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_nodone", 64'(done_seen), 64'(d0));
        acc.delete();
        start(6);
        tick(2);
        cfg_seed = 32'h1234;
        cfg_seed_load = 1'b1;
        cfg_burst_len = 16'd2;
        cfg_start = 1'b1;
        tick();
        cfg_seed_load = 1'b0;
        cfg_start = 1'b0;
        wait_done("run_ignore");
        check("run_ignore_n", 64'(acc.size()), 64'd6);
        check("run_ignore_cnt", 64'(word_cnt), 64'd6);

        d0 = done_seen;
        start(2);
        wait_cnt(1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_final_done", 64'(done), 64'd1);
        check("abort_final_cnt", 64'(word_cnt), 64'd2);
        tick();

        bus.m_ready = 1'b0;
        start(5);
        wait_valid("rst_mid");
        tick(2);
        up_rst = 1'b1;
        tick();
        up_rst = 1'b0;
        check("rst_mid_valid", 64'(bus.m_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cnt", 64'(word_cnt), 64'd0);
        bus.m_ready = 1'b1;
        acc.delete();
        start(1);
        wait_done("after_rst");
        if (acc.size() > 0) check("after_rst_w", 64'(acc[0]), 64'h1);
        else check("after_rst_n", 64'(acc.size()), 64'd1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
